axis_bram_writer: RTL
=====================

AXIS_BRAM_WRITER -- requirements
Module: axis_bram_writer

Interface
REQ-001 Parameter DATA_W, default 32, stream/BRAM data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 512, words per bank; SHALL be a power of two of at least 2.
REQ-003 Parameter ADDR_W, default 32, BRAM byte-address width.
REQ-004 Clock and reset SHALL be: clk  in  1  single clock; rst  in  1  asynchronous active-low reset.
REQ-005 en  in  1  arm; sampled only in IDLE.
REQ-006 s_axis_tdata  in  DATA_W  stream data.
REQ-007 s_axis_tvalid  in  1  beat valid.
REQ-008 s_axis_tready  out  1  beat ready.
REQ-009 s_axis_tlast  in  1  last beat of frame.
REQ-010 clka  out  1  driven by clk; rsta  out  1  tied 0.
REQ-011 ena  out  1  BRAM enable; wea  out  DATA_W/8  byte write enables.
REQ-012 addra  out  ADDR_W  BRAM byte address; dina  out  DATA_W  write data; douta  in  DATA_W  unused.
REQ-013 frame_done  out  1  one-cycle pulse at frame end.
REQ-014 frame_words  out  log2(DEPTH)+1  words written in the last completed frame.
REQ-015 frame_ovf  out  1  last completed frame was truncated.
REQ-016 bank  out  1  bank the current or next frame writes into.

Function
REQ-017 A beat SHALL transfer when s_axis_tvalid and s_axis_tready are both 1 at a rising clk edge.
REQ-018 FSM states SHALL be IDLE, WRITE and DRAIN.
REQ-019 s_axis_tready SHALL be en in IDLE, and 1 in WRITE and DRAIN.
REQ-020 A BRAM write SHALL occur combinationally in the handshake cycle with zero latency: ena=1, wea=all ones, dina=s_axis_tdata, addra=bank_base+wcount*(DATA_W/8); otherwise ena=0 and wea=0.
REQ-021 bank_base SHALL be bank*DEPTH*(DATA_W/8), truncated to ADDR_W.
REQ-022 wcount SHALL be an internal register of width log2(DEPTH)+1 holding words written in the current frame.
REQ-023 In IDLE, a transfer without tlast SHALL write, set wcount=1 and move to WRITE.
REQ-024 In WRITE, a transfer without tlast and with wcount<DEPTH SHALL write and increment wcount.
REQ-025 In WRITE, a transfer with wcount==DEPTH SHALL NOT write; the FSM SHALL move to DRAIN, or end the frame as truncated if that beat carries tlast.
REQ-026 In DRAIN, transfers SHALL be accepted and discarded until a tlast beat, which SHALL end the frame as truncated.
REQ-027 A tlast transfer in IDLE, or in WRITE with wcount<DEPTH, SHALL write and end the frame untruncated.
REQ-028 On frame end the block SHALL do all of the following on the next cycle: pulse frame_done; load frame_words with words written; set frame_ovf to the truncation status; clear wcount; toggle bank; return to IDLE.
REQ-029 frame_words and frame_ovf SHALL hold their values until the next frame end.
REQ-030 Deasserting en mid-frame SHALL NOT stop the frame; the frame SHALL complete on tlast.
REQ-031 An IDLE tlast beat SHALL be a one-word frame: frame_words=1.

Reset
REQ-032 While rst=0, the FSM SHALL be IDLE and wcount, bank, frame_done, frame_words and frame_ovf SHALL be 0.
REQ-033 While rst=0, s_axis_tready, ena and wea SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame without a frame_done pulse; the next beat SHALL write bank 0, address 0.

Configuration
REQ-035 Macro AXIS_BRAM_PINGPONG_EN defined: bank SHALL toggle per REQ-028, giving a 2*DEPTH-word double buffer.
REQ-036 Macro AXIS_BRAM_PINGPONG_EN undefined: bank SHALL be constant 0 and every frame SHALL write from byte address 0.

Verification (DATA_W=32, DEPTH=8, PINGPONG_EN defined unless stated)
REQ-037 en=1; 4 beats 0xA0..0xA3 with tlast on 4th -> addra 0,4,8,12 with wea=0xF; frame_done pulse; frame_words=4; frame_ovf=0; bank=1.
REQ-038 Second 2-beat frame -> addra 32,36; frame_words=2; bank returns to 0.
REQ-039 12-beat frame -> 8 writes at addra 0..28, beats 9-12 accepted and not written; frame_words=8; frame_ovf=1.
REQ-040 Single tlast beat in IDLE -> one write at addra 0; frame_words=1; FSM remains IDLE.
REQ-041 en=0 in IDLE -> s_axis_tready=0, no writes. en dropped after beat 2 of a 5-beat frame -> all 5 beats written.
REQ-042 rst=0 after beat 3 of a frame -> no frame_done; next frame starts at addra 0, bank 0. Macro undefined: two frames both start at addra 0.

Source files
------------

// File: rtl/axis_bram_writer_if.sv
// axis_bram_writer_if: AXI-Stream beat bundle (tdata/tvalid/tready/tlast)
// Ports: master drives tdata/tvalid/tlast and samples tready; slave is the mirror.
interface axis_bram_writer_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_bram_writer.sv
// axis_bram_writer: writes AXI-Stream frames into a BRAM port, one word per beat
// Ports: clk/rst (async, active-low); en arms a frame from IDLE; s_axis stream slave;
//   clka/rsta/ena/wea/addra/dina/douta BRAM port A (douta ignored);
//   frame_done pulse, frame_words/frame_ovf status of the last frame, bank in use.
// Macro AXIS_BRAM_PINGPONG_EN: alternate frames between two DEPTH-word banks;
//   without it every frame starts at byte address 0.
module axis_bram_writer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  axis_bram_writer_if.slave        s_axis,
  output logic                     clka,
  output logic                     rsta,
  output logic                     ena,
  output logic [DATA_W/8-1:0]      wea,
  output logic [ADDR_W-1:0]        addra,
  output logic [DATA_W-1:0]        dina,
  input  logic [DATA_W-1:0]        douta,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   frame_words,
  output logic                     frame_ovf,
  output logic                     bank
);
  localparam int WC_W = $clog2(DEPTH) + 1;
  localparam int BPW  = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, WRITE, DRAIN} state_t;
  state_t            state;
  logic [WC_W-1:0]   wcount;
  logic              full;
  logic              xfer;
  logic              wr;
  logic [ADDR_W-1:0] bank_base;
  logic              unused_douta;
  assign unused_douta = ^douta;
  assign clka = clk;
  assign rsta = 1'b0;
  assign full = wcount == WC_W'(DEPTH);
  // tready is gated by rst so nothing is accepted while reset is held
  assign s_axis.tready = rst && (state != IDLE || en);
  assign xfer = s_axis.tvalid && s_axis.tready;
  assign wr = xfer && state != DRAIN && !full;
  assign ena = wr;
  assign wea = {BPW{wr}};
  assign dina = s_axis.tdata;
  assign bank_base = bank ? ADDR_W'(DEPTH * BPW) : '0;
  assign addra = bank_base + ADDR_W'(wcount) * ADDR_W'(BPW);
`ifndef AXIS_BRAM_PINGPONG_EN
  assign bank = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wcount      <= '0;
      frame_done  <= 1'b0;
      frame_words <= '0;
      frame_ovf   <= 1'b0;
`ifdef AXIS_BRAM_PINGPONG_EN
      bank        <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (xfer) begin
        if (s_axis.tlast) begin
          // a tlast beat that could not be written marks the frame truncated
          state       <= IDLE;
          frame_done  <= 1'b1;
          frame_words <= wcount + WC_W'(wr);
          frame_ovf   <= !wr;
          wcount      <= '0;
`ifdef AXIS_BRAM_PINGPONG_EN
          bank        <= ~bank;
`endif
        end else if (wr) begin
          state  <= WRITE;
          wcount <= wcount + 1'b1;
        end else begin
          state <= DRAIN;
        end
      end
    end
  end
endmodule
